uart_tx_unit: RTL and testbench

Transmit half of the APB UART. Accepts parallel bytes from the APB slave into a transmit FIFO and serialises each byte onto tx_out as one frame, running on the baud clock:
- 1 start bit (0)
- 8 data bits, LSB first
- 1 parity bit
- STOP_BITS stop bits (1)

It drives the line that the receive unit samples, and reports its status and errors back to the APB slave.

---
 rtl/uart_tx_unit_if.sv | 24 ++
 rtl/uart_tx_unit.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_unit_if.sv
// APB-side handshake and status bundle of the UART transmit unit.
// The serial line and clock/reset stay as plain ports on the unit.
interface uart_tx_unit_if;
  logic       transmit;
  logic [7:0] data_in;
  logic       send_break;
  logic       clr_err;
  logic       PREADY_T;
  logic       TxFF;
  logic       TxFE;
  logic       tx_busy;
  logic       tx_done;
  logic       OVF;

  modport master (
    output transmit, data_in, send_break, clr_err,
    input  PREADY_T, TxFF, TxFE, tx_busy, tx_done, OVF
  );

  modport slave (
    input  transmit, data_in, send_break, clr_err,
    output PREADY_T, TxFF, TxFE, tx_busy, tx_done, OVF
  );
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: byte FIFO feeding a start/8-data/parity/stop serialiser,
// one serial bit per baud_clk, with break generation and sticky overflow.
module uart_tx_unit #(
  parameter int FIFO_DEPTH_T = 16,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic           baud_clk,
  input  logic           rst,
  uart_tx_unit_if.slave  bus,
  output logic           tx_out
);

  localparam int PtrW = $clog2(FIFO_DEPTH_T);
  localparam int CntW = PtrW + 1;
  localparam logic StopLast = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e            state_q, state_d;
  logic              txOut_q, txOut_d;
  logic [7:0]        shiftReg_q, shiftReg_d;
  logic              parity_q, parity_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic              stopCnt_q, stopCnt_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [FIFO_DEPTH_T];

  logic              fifoFull;
  logic              fifoEmpty;
  logic              push;
  logic              pop;
  logic              decide;
  logic              lastStop;
  logic [7:0]        head;

  assign fifoFull  = (count_q == CntW'(FIFO_DEPTH_T));
  assign fifoEmpty = (count_q == '0);
  assign push      = bus.transmit && !fifoFull;
  assign head      = mem_q[rdPtr_q];
  assign lastStop  = (state_q == S_STOP) && (stopCnt_q == StopLast);

  always_comb begin
    state_d    = state_q;
    txOut_d    = txOut_q;
    shiftReg_d = shiftReg_q;
    parity_d   = parity_q;
    bitCnt_d   = bitCnt_q;
    stopCnt_d  = stopCnt_q;
    pop        = 1'b0;
    decide     = 1'b0;

    unique case (state_q)
      S_IDLE: decide = 1'b1;
      S_START: begin
        txOut_d  = shiftReg_q[0];
        bitCnt_d = 3'd0;
        state_d  = S_DATA;
      end
      S_DATA: begin
        if (bitCnt_q != 3'd7) begin
          txOut_d  = shiftReg_q[bitCnt_q + 3'd1];
          bitCnt_d = bitCnt_q + 3'd1;
        end else begin
          txOut_d = parity_q;
          state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        txOut_d   = 1'b1;
        stopCnt_d = 1'b0;
        state_d   = S_STOP;
      end
      S_STOP: begin
        if (lastStop) begin
          decide = 1'b1;
        end else begin
          txOut_d   = 1'b1;
          stopCnt_d = stopCnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (bus.send_break) begin
          txOut_d = 1'b0;
        end else begin
          txOut_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        txOut_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Idle and frame end share one arbitration so frames run back-to-back.
    if (decide) begin
      if (bus.send_break) begin
        txOut_d = 1'b0;
        state_d = S_BREAK;
      end else if (!fifoEmpty) begin
        txOut_d    = 1'b0;
        shiftReg_d = head;
        parity_d   = (^head) ^ PARITY_ODD;
        pop        = 1'b1;
        state_d    = S_START;
      end else begin
        txOut_d = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PtrW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PtrW'(1) : rdPtr_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    ovf_d   = ovf_q;
    // A dropped write outranks a simultaneous clear.
    if (bus.transmit && fifoFull) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      txOut_q    <= 1'b1;
      shiftReg_q <= '0;
      parity_q   <= 1'b0;
      bitCnt_q   <= '0;
      stopCnt_q  <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txOut_q    <= txOut_d;
      shiftReg_q <= shiftReg_d;
      parity_q   <= parity_d;
      bitCnt_q   <= bitCnt_d;
      stopCnt_q  <= stopCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.data_in;
    end
  end

  assign tx_out       = txOut_q;
  assign bus.PREADY_T = !fifoFull;
  assign bus.TxFF     = fifoFull;
  assign bus.TxFE     = fifoEmpty;
  assign bus.tx_busy  = (state_q != S_IDLE);
  assign bus.tx_done  = lastStop;
  assign bus.OVF      = ovf_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: a default instance (even parity, one stop)
// and a second instance with odd parity and two stop bits.
module tb_uart_tx_unit;

  logic       clock;
  logic       reset;
  logic       transmit;
  logic [7:0] dataIn;
  logic       sendBreak;
  logic       clrErr;
  logic       txOut0;
  logic       txOut1;

  int total = 0;
  int bad   = 0;

  uart_tx_unit_if bus0 ();
  uart_tx_unit_if bus1 ();

  assign bus0.transmit   = transmit;
  assign bus0.data_in    = dataIn;
  assign bus0.send_break = sendBreak;
  assign bus0.clr_err    = clrErr;
  assign bus1.transmit   = transmit;
  assign bus1.data_in    = dataIn;
  assign bus1.send_break = sendBreak;
  assign bus1.clr_err    = clrErr;

  uart_tx_unit #(.FIFO_DEPTH_T(16), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
    .baud_clk (clock),
    .rst      (reset),
    .bus      (bus0),
    .tx_out   (txOut0)
  );

  uart_tx_unit #(.FIFO_DEPTH_T(16), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut1 (
    .baud_clk (clock),
    .rst      (reset),
    .bus      (bus1),
    .tx_out   (txOut1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       transmit;
    logic [7:0] data;
    logic       brk;
    logic       clr;
    logic       expTx;
    logic       expDone;
    logic       expBusy;
    logic       expFe;
  } vec_t;

  vec_t vecs[14];

  // Expected line level at position idx of a frame (0 = start bit).
  function automatic logic frameBit(input logic [7:0] b, input logic odd, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else if (idx == 9) return (^b) ^ odd;
    else return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic t, input logic [7:0] d, input logic b, input logic c);
    transmit  = t;
    dataIn    = d;
    sendBreak = b;
    clrErr    = c;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((bus0.tx_busy || bus1.tx_busy || !bus0.TxFE || !bus1.TxFE) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("idle reached", (n < 300), 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    transmit  = 1'b0;
    dataIn    = 8'h00;
    sendBreak = 1'b0;
    clrErr    = 1'b0;
    tick();
    tick();
    checkOutput("reset tx_out",  txOut0, 1'b1);
    checkOutput("reset TxFE",    bus0.TxFE, 1'b1);
    checkOutput("reset TxFF",    bus0.TxFF, 1'b0);
    checkOutput("reset busy",    bus0.tx_busy, 1'b0);
    checkOutput("reset done",    bus0.tx_done, 1'b0);
    checkOutput("reset OVF",     bus0.OVF, 1'b0);
    checkOutput("reset PREADY",  bus0.PREADY_T, 1'b1);
    reset = 1'b0;

    // 0xA5, even parity, one stop bit: 0,1,0,1,0,0,1,0,1,0,1
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].transmit, vecs[i].data, vecs[i].brk, vecs[i].clr);
      checkOutput($sformatf("vec%0d tx_out", i), txOut0, vecs[i].expTx);
      checkOutput($sformatf("vec%0d tx_done", i), bus0.tx_done, vecs[i].expDone);
      checkOutput($sformatf("vec%0d tx_busy", i), bus0.tx_busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d TxFE", i), bus0.TxFE, vecs[i].expFe);
    end

    $display("[TB] odd parity, two stop bits");
    waitIdle();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int idx = 0; idx < 13; idx++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("odd2 bit%0d", idx), txOut1, frameBit(8'hA5, 1'b1, idx));
      checkOutput($sformatf("odd2 done%0d", idx), bus1.tx_done, (idx == 11));
      checkOutput($sformatf("odd2 busy%0d", idx), bus1.tx_busy, (idx < 12));
    end

    $display("[TB] back-to-back frames");
    waitIdle();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("b2b first start", txOut0, 1'b0);
    checkOutput("b2b FE after first pop", bus0.TxFE, 1'b0);
    for (int k = 1; k < 22; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("b2b tx%0d", k), txOut0,
                  frameBit((k >= 11) ? 8'hFF : 8'h00, 1'b0, k % 11));
      checkOutput($sformatf("b2b busy%0d", k), bus0.tx_busy, 1'b1);
      checkOutput($sformatf("b2b FE%0d", k), bus0.TxFE, (k >= 11));
      checkOutput($sformatf("b2b done%0d", k), bus0.tx_done, ((k % 11) == 10));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("b2b end busy", bus0.tx_busy, 1'b0);
    checkOutput("b2b end tx", txOut0, 1'b1);

    $display("[TB] fill during break");
    waitIdle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("brk line low", txOut0, 1'b0);
    checkOutput("brk busy", bus0.tx_busy, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(16 + i), 1'b1, 1'b0);
      checkOutput($sformatf("fill%0d TxFF", i), bus0.TxFF, (i == 15));
      checkOutput($sformatf("fill%0d PREADY", i), bus0.PREADY_T, (i != 15));
      checkOutput($sformatf("fill%0d OVF", i), bus0.OVF, 1'b0);
    end
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("overflow OVF", bus0.OVF, 1'b1);
    checkOutput("overflow TxFF", bus0.TxFF, 1'b1);
    applyStimulus(1'b1, 8'hEF, 1'b1, 1'b1);
    checkOutput("ovf set beats clr", bus0.OVF, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("clr_err clears OVF", bus0.OVF, 1'b0);
    checkOutput("still full", bus0.TxFF, 1'b1);
    checkOutput("still in break", txOut0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("brk release tx", txOut0, 1'b1);
    checkOutput("brk release busy", bus0.tx_busy, 1'b0);
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 11; i++) begin
        tick();
        checkOutput($sformatf("drain f%0d b%0d", f, i), txOut0, frameBit(8'(16 + f), 1'b0, i));
      end
    end
    tick();
    checkOutput("drain end busy", bus0.tx_busy, 1'b0);
    checkOutput("drain end FE", bus0.TxFE, 1'b1);

    $display("[TB] break requested mid-frame");
    waitIdle();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("mid start", txOut0, 1'b0);
    for (int i = 1; i < 11; i++) begin
      applyStimulus(1'b0, 8'h00, (i >= 4), 1'b0);
      checkOutput($sformatf("mid bit%0d", i), txOut0, frameBit(8'h3C, 1'b0, i));
      checkOutput($sformatf("mid done%0d", i), bus0.tx_done, (i == 10));
    end
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("held brk%0d tx", j), txOut0, 1'b0);
      checkOutput($sformatf("held brk%0d FE", j), bus0.TxFE, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid release tx", txOut0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("resume bit%0d", i), txOut0, frameBit(8'hC3, 1'b0, i));
    end

    $display("[TB] reset mid-frame");
    waitIdle();
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("rst pre bit1", txOut0, frameBit(8'h5A, 1'b0, 1));
    for (int i = 2; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("rst pre bit%0d", i), txOut0, frameBit(8'h5A, 1'b0, i));
    end
    checkOutput("rst pre FE", bus0.TxFE, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst mid tx", txOut0, 1'b1);
    checkOutput("rst mid FE", bus0.TxFE, 1'b1);
    checkOutput("rst mid busy", bus0.tx_busy, 1'b0);
    checkOutput("rst mid OVF", bus0.OVF, 1'b0);
    checkOutput("rst mid TxFF", bus0.TxFF, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("post rst tx%0d", i), txOut0, 1'b1);
      checkOutput($sformatf("post rst busy%0d", i), bus0.tx_busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
